// File: rtl/pc_register_pkg.sv
// Shared definitions for the fetch-stage PC register: FSM state encoding and default reset PC.
// The 3-bit state values match the legacy header encoding so waveforms and debug tools line up.
package pc_register_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_WAIT_STEP = 3'd2,
        ST_STEP      = 3'd3,
        ST_HALTED    = 3'd4
    } pc_state_t;

    localparam logic [31:0] PC_DEFAULT_RESET = 32'h0000_0000;

    function automatic logic is_fetch_state(input pc_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pc_step_fsm.sv
// Run/step/halt sequencer for the PC register: state register plus Moore decode of
// pc_valid/halted, and the PC load enable for the current cycle.
module pc_step_fsm
    import pc_register_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_mode_step,
    input  logic i_step_pulse,
    input  logic i_stall,
    input  logic i_halt,
    output logic o_pc_load,
    output logic o_pc_valid,
    output logic o_halted
);

    pc_state_t r_state;
    pc_state_t w_state_next;
    logic      r_pc_valid;
    logic      r_halted;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = i_mode_step ? ST_WAIT_STEP : ST_RUN;
                end
            end
            ST_RUN:       w_state_next = ST_RUN;
            ST_WAIT_STEP: begin
                if (i_step_pulse) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                if (!i_stall) begin
                    w_state_next = ST_WAIT_STEP;
                end
            end
            ST_HALTED:    w_state_next = ST_HALTED;
            default:      w_state_next = ST_IDLE;
        endcase
        // A decoded HALT overrides everything below reset, including stall.
        if (i_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    assign o_pc_load = is_fetch_state(r_state) && !i_stall && !i_halt;

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc_valid <= is_fetch_state(w_state_next);
            r_halted   <= (w_state_next == ST_HALTED);
        end
    end

    assign o_pc_valid = r_pc_valid;
    assign o_halted   = r_halted;

endmodule

// File: rtl/pc_register.sv
// MIPS fetch-stage program counter with debug run/step/halt sequencing.
// Define PC_CYCLE_COUNTER_EN to add the saturating retired-fetch counter port cycle_count.
module pc_register
    import pc_register_pkg::*;
#(
    parameter int                  len_data = 32,
    parameter logic [len_data-1:0] RESET_PC = len_data'(PC_DEFAULT_RESET)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [len_data-1:0] pc_next,
    input  logic                stall,
    input  logic                start,
    input  logic                mode_step,
    input  logic                step_pulse,
    input  logic                halt_detected,
    output logic [len_data-1:0] pc_out,
    output logic                pc_valid,
    output logic                halted
`ifdef PC_CYCLE_COUNTER_EN
    ,
    output logic [31:0]         cycle_count
`endif
);

    localparam logic [len_data-1:0] PC_ALIGN_MASK = {{(len_data-2){1'b1}}, 2'b00};

    logic                w_pc_load;
    logic                w_pc_valid;
    logic                w_halted;
    logic [len_data-1:0] r_pc;
    logic                w_pc_lsb_unused;

    pc_step_fsm u_fsm (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_start      (start),
        .i_mode_step  (mode_step),
        .i_step_pulse (step_pulse),
        .i_stall      (stall),
        .i_halt       (halt_detected),
        .o_pc_load    (w_pc_load),
        .o_pc_valid   (w_pc_valid),
        .o_halted     (w_halted)
    );

    // Word alignment: the two low bits of the mux output never reach the PC.
    assign w_pc_lsb_unused = ^pc_next[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC & PC_ALIGN_MASK;
        end else if (w_pc_load) begin
            r_pc <= {pc_next[len_data-1:2], 2'b00};
        end
    end

    assign pc_out   = r_pc;
    assign pc_valid = w_pc_valid;
    assign halted   = w_halted;

`ifdef PC_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_pc_valid && !stall && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_pc_register.sv
// Directed self-checking bench for pc_register: reset, run, stall, single-step, halt and wrap.
module tb_pc_register;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_next = '0;
    logic        stall = 1'b0;
    logic        start = 1'b0;
    logic        mode_step = 1'b0;
    logic        step_pulse = 1'b0;
    logic        halt_detected = 1'b0;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        halted;
`ifdef PC_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    pc_register #(.len_data(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .stall         (stall),
        .start         (start),
        .mode_step     (mode_step),
        .step_pulse    (step_pulse),
        .halt_detected (halt_detected),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .halted        (halted)
`ifdef PC_CYCLE_COUNTER_EN
        ,
        .cycle_count   (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; mode_step = 0; step_pulse = 0; stall = 0; halt_detected = 0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({pc_out, pc_valid, halted} !== {32'h0, 1'b0, 1'b0})
            $display("FAIL reset_state: pc=%h valid=%b halted=%b, expected pc=00000000 valid=0 halted=0",
                     pc_out, pc_valid, halted);
        else n_pass++;
`ifdef PC_CYCLE_COUNTER_EN
        n_checks++;
        if (cycle_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cycle_count);
        else n_pass++;
`endif
        tick();
        reset = 1'b0;
        pc_next = 32'h100;
        tick();
        n_checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0})
            $display("FAIL idle_hold: pc=%h valid=%b, expected pc=00000000 valid=0", pc_out, pc_valid);
        else n_pass++;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        start = 1'b1; mode_step = 1'b0; pc_next = 32'h4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({pc_out, pc_valid} !== {exp_pc[i], 1'b1})
                $display("FAIL run_seq[%0d]: pc=%h valid=%b, expected pc=%h valid=1", i, pc_out, pc_valid, exp_pc[i]);
            else n_pass++;
            if (i < 4) begin
                pc_next = exp_pc[i+1];
                tick();
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        pc_next = 32'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({pc_out, pc_valid} !== {32'h10, 1'b1})
                $display("FAIL stall_hold[%0d]: pc=%h valid=%b, expected pc=00000010 valid=1", i, pc_out, pc_valid);
            else n_pass++;
`ifdef PC_CYCLE_COUNTER_EN
            n_checks++;
            if (cycle_count !== 32'd4) $display("FAIL stall_count[%0d]: got %0d expected 4", i, cycle_count);
            else n_pass++;
`endif
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (pc_out !== 32'h14) $display("FAIL stall_resume: pc=%h expected 00000014", pc_out);
        else n_pass++;
`ifdef PC_CYCLE_COUNTER_EN
        n_checks++;
        if (cycle_count !== 32'd5) $display("FAIL resume_count: got %0d expected 5", cycle_count);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_run();
        pc_next = 32'h40;
        tick();
        n_checks++;
        if (pc_out !== 32'h40) $display("FAIL pre_reset_pc: pc=%h expected 00000040", pc_out);
        else n_pass++;
        pc_next = 32'h44;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({pc_out, pc_valid, halted} !== {32'h0, 1'b0, 1'b0})
            $display("FAIL async_reset: pc=%h valid=%b halted=%b, expected pc=00000000 valid=0 halted=0",
                     pc_out, pc_valid, halted);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0})
            $display("FAIL reset_to_idle: pc=%h valid=%b, expected pc=00000000 valid=0", pc_out, pc_valid);
        else n_pass++;
    endtask

    task automatic test_step();
        logic exp_valid;
        logic [31:0] exp_pc;
        do_reset();
        start = 1'b1; mode_step = 1'b1; pc_next = 32'h4;
        tick();
        start = 1'b0; mode_step = 1'b0;
        tick();
        n_checks++;
        if ({pc_out, pc_valid} !== {32'h0, 1'b0})
            $display("FAIL wait_step: pc=%h valid=%b, expected pc=00000000 valid=0", pc_out, pc_valid);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            pc_next = 32'(4 * k);
            for (int c = 0; c < 4; c++) begin
                // Second pulse of the first step lands while in STEP and must not queue.
                step_pulse = (c == 0) || (k == 1 && c == 1);
                tick();
                exp_valid = (c == 0);
                exp_pc    = (c == 0) ? 32'(4 * (k - 1)) : 32'(4 * k);
                n_checks++;
                if ({pc_out, pc_valid} !== {exp_pc, exp_valid})
                    $display("FAIL step[%0d][%0d]: pc=%h valid=%b, expected pc=%h valid=%b",
                             k, c, pc_out, pc_valid, exp_pc, exp_valid);
                else n_pass++;
            end
        end
        step_pulse = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        start = 1'b1; pc_next = 32'h20;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (pc_out !== 32'h20) $display("FAIL pre_halt_pc: pc=%h expected 00000020", pc_out);
        else n_pass++;
        halt_detected = 1'b1; stall = 1'b1; pc_next = 32'h24;
        tick();
        halt_detected = 1'b0; stall = 1'b0;
        n_checks++;
        if ({pc_out, pc_valid, halted} !== {32'h20, 1'b0, 1'b1})
            $display("FAIL halt_enter: pc=%h valid=%b halted=%b, expected pc=00000020 valid=0 halted=1",
                     pc_out, pc_valid, halted);
        else n_pass++;
`ifdef PC_CYCLE_COUNTER_EN
        n_checks++;
        if (cycle_count !== 32'd1) $display("FAIL halt_count: got %0d expected 1", cycle_count);
        else n_pass++;
`endif
        start = 1'b1; step_pulse = 1'b1; mode_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({pc_out, pc_valid, halted} !== {32'h20, 1'b0, 1'b1})
                $display("FAIL halt_frozen[%0d]: pc=%h valid=%b halted=%b, expected pc=00000020 valid=0 halted=1",
                         i, pc_out, pc_valid, halted);
            else n_pass++;
        end
        start = 1'b0; step_pulse = 1'b0;
        do_reset();
        n_checks++;
        if ({pc_out, pc_valid, halted} !== {32'h0, 1'b0, 1'b0})
            $display("FAIL halt_reset: pc=%h valid=%b halted=%b, expected pc=00000000 valid=0 halted=0",
                     pc_out, pc_valid, halted);
        else n_pass++;
    endtask

    task automatic test_wrap_align();
        do_reset();
        start = 1'b1; pc_next = 32'hFFFF_FFFC;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_top: pc=%h expected fffffffc", pc_out);
        else n_pass++;
        pc_next = 32'h0000_0003;
        tick();
        n_checks++;
        if (pc_out !== 32'h0) $display("FAIL wrap_zero: pc=%h expected 00000000", pc_out);
        else n_pass++;
        pc_next = 32'h0000_0013;
        tick();
        n_checks++;
        if (pc_out !== 32'h10) $display("FAIL align_lsb: pc=%h expected 00000010", pc_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_reset_mid_run();
        test_step();
        test_halt();
        test_wrap_align();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
